// File: rtl/int_prio_pkg.sv
// rtl/int_prio_pkg.sv - shared types, vector defaults and address helper for int_prio_ctrl
package int_prio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   localparam logic [15:0] VEC_BASE_DEF   = 16'h0003;
   localparam logic [15:0] VEC_STRIDE_DEF = 16'h0008;
   localparam int          IDX_W          = 4;

   // Vector address wraps modulo 2^16.
   function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                            input logic [15:0] stride,
                                            input logic [IDX_W-1:0] idx);
      return base + stride * {{(16-IDX_W){1'b0}}, idx};
   endfunction

endpackage

// File: rtl/int_prio_select.sv
// rtl/int_prio_select.sv - combinational eligibility, two-level priority and nesting gate
module int_prio_select
   import int_prio_pkg::*;
#(
   parameter int NUM_SRC = 5
) (
   input  logic               i_ie_ea,
   input  logic [NUM_SRC-1:0] i_ie_en,
   input  logic [NUM_SRC-1:0] i_ip,
   input  logic [NUM_SRC-1:0] i_src_req,
   input  logic [1:0]         i_in_service,
   output logic [NUM_SRC-1:0] o_elig,
   output logic               o_valid,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_level
);

   logic [NUM_SRC-1:0] w_hi;
   logic [NUM_SRC-1:0] w_lo;
   logic [IDX_W-1:0]   w_hi_idx;
   logic [IDX_W-1:0]   w_lo_idx;

   assign o_elig = i_src_req & i_ie_en & {NUM_SRC{i_ie_ea}};

   always_comb begin
      w_hi     = o_elig & i_ip;
      w_lo     = o_elig & ~i_ip;
      w_hi_idx = '0;
      w_lo_idx = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_hi[i]) w_hi_idx = IDX_W'(i);
         if (w_lo[i]) w_lo_idx = IDX_W'(i);
      end
      o_level = |w_hi;
      o_idx   = (|w_hi) ? w_hi_idx : w_lo_idx;
      o_valid = (|w_hi) ? ~i_in_service[1] : ((|w_lo) && (i_in_service == 2'b00));
   end

endmodule

// File: rtl/int_prio_ctrl.sv
// rtl/int_prio_ctrl.sv - 8051-style two-level interrupt priority controller
module int_prio_ctrl
   import int_prio_pkg::*;
#(
   parameter int          NUM_SRC    = 5,
   parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ie_ea,
   input  logic [NUM_SRC-1:0] ie_en,
   input  logic [NUM_SRC-1:0] ip,
   input  logic [NUM_SRC-1:0] src_req,
   input  logic [NUM_SRC-1:0] edge_mode,
   input  logic               int_ack,
   input  logic               reti,
   output logic               int_req,
   output logic [15:0]        int_vec,
   output logic [NUM_SRC-1:0] clr_flag,
   output logic [1:0]         in_service
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_level;
   logic [15:0]        r_vec;
   logic [NUM_SRC-1:0] r_clr;
   logic [1:0]         r_is;

   logic [NUM_SRC-1:0] w_elig;
   logic               w_win_valid;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_win_level;
   logic [NUM_SRC-1:0] w_lat_mask;
   logic               w_lat_elig;
   logic               w_ack_ok;
   logic [1:0]         w_is_nxt;

   int_prio_select #(.NUM_SRC(NUM_SRC)) u_select (
      .i_ie_ea      (ie_ea),
      .i_ie_en      (ie_en),
      .i_ip         (ip),
      .i_src_req    (src_req),
      .i_in_service (r_is),
      .o_elig       (w_elig),
      .o_valid      (w_win_valid),
      .o_idx        (w_win_idx),
      .o_level      (w_win_level)
   );

   assign w_lat_mask = NUM_SRC'(1) << r_idx;
   assign w_lat_elig = |(w_elig & w_lat_mask);
   assign w_ack_ok   = (r_state == ST_REQ) && int_ack;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (reti)             w_state_nxt = ST_BLANK;
            else if (w_win_valid) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (reti)             w_state_nxt = ST_BLANK;
            else if (int_ack)     w_state_nxt = ST_IDLE;
            else if (!w_lat_elig) w_state_nxt = ST_IDLE;
         end
         ST_BLANK: w_state_nxt = reti ? ST_BLANK : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // RETI retires the innermost level first; a same-cycle acknowledge sets afterwards.
   always_comb begin
      w_is_nxt = r_is;
      if (reti) begin
         if (r_is[1]) w_is_nxt[1] = 1'b0;
         else         w_is_nxt[0] = 1'b0;
      end
      if (w_ack_ok) begin
         if (r_level) w_is_nxt[1] = 1'b1;
         else         w_is_nxt[0] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_level <= 1'b0;
         r_vec   <= 16'h0000;
         r_clr   <= '0;
         r_is    <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_is    <= w_is_nxt;
         r_clr   <= (w_ack_ok && |(edge_mode & w_lat_mask)) ? w_lat_mask : '0;
         if ((r_state == ST_IDLE) && (w_state_nxt == ST_REQ)) begin
            r_idx   <= w_win_idx;
            r_level <= w_win_level;
            r_vec   <= vec_addr(VEC_BASE, VEC_STRIDE, w_win_idx);
         end
      end
   end

   assign int_req    = (r_state == ST_REQ);
   assign int_vec    = r_vec;
   assign clr_flag   = r_clr;
   assign in_service = r_is;

endmodule

// File: tb/tb_int_prio_ctrl.sv
// tb/tb_int_prio_ctrl.sv - directed self-checking bench for int_prio_ctrl
module tb_int_prio_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ie_ea;
   logic [4:0]  ie_en;
   logic [4:0]  ip;
   logic [4:0]  src_req;
   logic [4:0]  edge_mode;
   logic        int_ack;
   logic        reti;
   logic        int_req;
   logic [15:0] int_vec;
   logic [4:0]  clr_flag;
   logic [1:0]  in_service;

   int n_tests = 0;
   int n_fail  = 0;

   int_prio_ctrl #(.NUM_SRC(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ie_ea      (ie_ea),
      .ie_en      (ie_en),
      .ip         (ip),
      .src_req    (src_req),
      .edge_mode  (edge_mode),
      .int_ack    (int_ack),
      .reti       (reti),
      .int_req    (int_req),
      .int_vec    (int_vec),
      .clr_flag   (clr_flag),
      .in_service (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ie_ea = 1'b0; ie_en = '0; ip = '0; src_req = '0;
      edge_mode = '0; int_ack = 1'b0; reti = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", int_req); end
      n_tests++; if (int_vec !== 16'h0000) begin n_fail++; $display("FAIL rst_vec: got %h want 0000", int_vec); end
      n_tests++; if (clr_flag !== 5'h00) begin n_fail++; $display("FAIL rst_clr: got %h want 00", clr_flag); end
      n_tests++; if (in_service !== 2'b00) begin n_fail++; $display("FAIL rst_is: got %b want 00", in_service); end
   endtask

   task automatic test_basic();
      do_reset();
      ie_ea = 1; ie_en = 5'h01; edge_mode = 5'h01; src_req = 5'h01;
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_pre: got %b want 0", int_req); end
      tick();
      n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", int_req); end
      n_tests++; if (int_vec !== 16'h0003) begin n_fail++; $display("FAIL basic_vec: got %h want 0003", int_vec); end
      int_ack = 1; tick(); int_ack = 0;
      n_tests++; if (clr_flag !== 5'h01) begin n_fail++; $display("FAIL basic_clr: got %h want 01", clr_flag); end
      n_tests++; if (in_service !== 2'b01) begin n_fail++; $display("FAIL basic_is: got %b want 01", in_service); end
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_ackdrop: got %b want 0", int_req); end
      src_req = 5'h00; tick();
      n_tests++; if (clr_flag !== 5'h00) begin n_fail++; $display("FAIL basic_clr_pulse: got %h want 00", clr_flag); end
      reti = 1; tick(); reti = 0;
      n_tests++; if (in_service !== 2'b00) begin n_fail++; $display("FAIL basic_reti: got %b want 00", in_service); end
   endtask

   task automatic test_low_order();
      do_reset();
      ie_ea = 1; ie_en = 5'h1F; ip = 5'h00; edge_mode = 5'h00; src_req = 5'h06;
      tick();
      n_tests++; if (int_vec !== 16'h000B || int_req !== 1'b1) begin n_fail++; $display("FAIL low_vec1: got %h/%b want 000B/1", int_vec, int_req); end
      int_ack = 1; tick(); int_ack = 0;
      n_tests++; if (clr_flag !== 5'h00) begin n_fail++; $display("FAIL low_noclr: got %h want 00", clr_flag); end
      src_req = 5'h04; tick();
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL low_blocked: got %b want 0", int_req); end
      reti = 1; tick(); reti = 0;
      n_tests++; if (int_req !== 1'b0 || in_service !== 2'b00) begin n_fail++; $display("FAIL low_blank: got %b/%b want 0/00", int_req, in_service); end
      tick();
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL low_idle: got %b want 0", int_req); end
      tick();
      n_tests++; if (int_vec !== 16'h0013 || int_req !== 1'b1) begin n_fail++; $display("FAIL low_vec2: got %h/%b want 0013/1", int_vec, int_req); end
   endtask

   task automatic test_high();
      do_reset();
      ie_ea = 1; ie_en = 5'h1F; ip = 5'h10; src_req = 5'h11;
      tick();
      n_tests++; if (int_vec !== 16'h0023) begin n_fail++; $display("FAIL high_vec: got %h want 0023", int_vec); end
      int_ack = 1; tick(); int_ack = 0;
      n_tests++; if (in_service !== 2'b10) begin n_fail++; $display("FAIL high_level: got %b want 10", in_service); end
   endtask

   task automatic test_gating();
      do_reset();
      ie_ea = 0; ie_en = 5'h1F; src_req = 5'h01;
      tick(); tick();
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL gate_ea: got %b want 0", int_req); end
      ie_ea = 1; ie_en = 5'h1E;
      tick(); tick();
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL gate_en: got %b want 0", int_req); end
      src_req = 5'h00; int_ack = 1; tick(); int_ack = 0;
      n_tests++; if (in_service !== 2'b00) begin n_fail++; $display("FAIL gate_stray_ack: got %b want 00", in_service); end
   endtask

   task automatic test_nesting();
      do_reset();
      ie_ea = 1; ie_en = 5'h1F; ip = 5'h08; edge_mode = 5'h00; src_req = 5'h01;
      tick(); int_ack = 1; tick(); int_ack = 0;
      src_req = 5'h02; tick(); tick();
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_low_block: got %b want 0", int_req); end
      src_req = 5'h0A; tick();
      n_tests++; if (int_req !== 1'b1 || int_vec !== 16'h001B) begin n_fail++; $display("FAIL nest_high: got %b/%h want 1/001B", int_req, int_vec); end
      int_ack = 1; tick(); int_ack = 0;
      n_tests++; if (in_service !== 2'b11) begin n_fail++; $display("FAIL nest_is11: got %b want 11", in_service); end
      src_req = 5'h02;
      reti = 1; tick(); reti = 0;
      n_tests++; if (in_service !== 2'b01) begin n_fail++; $display("FAIL nest_reti1: got %b want 01", in_service); end
      tick();
      n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_still_block: got %b want 0", int_req); end
      reti = 1; tick(); reti = 0;
      n_tests++; if (in_service !== 2'b00) begin n_fail++; $display("FAIL nest_reti2: got %b want 00", in_service); end
      tick(); tick();
      n_tests++; if (int_req !== 1'b1 || int_vec !== 16'h000B) begin n_fail++; $display("FAIL nest_src1: got %b/%h want 1/000B", int_req, int_vec); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ie_ea = 1; ie_en = 5'h1F; ip = 5'h08; edge_mode = 5'h00; src_req = 5'h01;
      tick(); int_ack = 1; tick(); int_ack = 0;
      src_req = 5'h08; tick();
      n_tests++; if (int_vec !== 16'h001B) begin n_fail++; $display("FAIL b2b_vec: got %h want 001B", int_vec); end
      int_ack = 1; reti = 1; tick(); int_ack = 0; reti = 0;
      n_tests++; if (int_req !== 1'b0 || in_service !== 2'b10) begin n_fail++; $display("FAIL b2b_both: got %b/%b want 0/10", int_req, in_service); end
      src_req = 5'h00; tick();
      reti = 1; tick(); reti = 0;
      n_tests++; if (in_service !== 2'b00) begin n_fail++; $display("FAIL b2b_reti: got %b want 00", in_service); end
      tick();
      src_req = 5'h04; tick();
      n_tests++; if (int_req !== 1'b1 || int_vec !== 16'h0013) begin n_fail++; $display("FAIL b2b_src2: got %b/%h want 1/0013", int_req, int_vec); end
      src_req = 5'h00; tick();
      n_tests++; if (int_req !== 1'b0 || in_service !== 2'b00) begin n_fail++; $display("FAIL b2b_withdraw: got %b/%b want 0/00", int_req, in_service); end
   endtask

   task automatic test_reset_mid_req();
      do_reset();
      ie_ea = 1; ie_en = 5'h1F; ip = 5'h08; edge_mode = 5'h09; src_req = 5'h01;
      tick(); int_ack = 1; tick(); int_ack = 0;
      src_req = 5'h08; tick();
      n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", int_req); end
      #2; rst_n = 1'b0; int_ack = 1; #1;
      n_tests++; if (int_req !== 1'b0 || int_vec !== 16'h0000 || in_service !== 2'b00 || clr_flag !== 5'h00) begin
         n_fail++; $display("FAIL mid_async: got %b/%h/%b/%h want 0/0000/00/00", int_req, int_vec, in_service, clr_flag);
      end
      tick();
      n_tests++; if (clr_flag !== 5'h00 || int_req !== 1'b0) begin n_fail++; $display("FAIL mid_hold: got %h/%b want 00/0", clr_flag, int_req); end
      int_ack = 0; rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_low_order();
      test_high();
      test_gating();
      test_nesting();
      test_back_to_back();
      test_reset_mid_req();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
